serial_alu: RTL and testbench



---
 rtl/serial_alu.sv | 141 ++++++++++++++
 tb/tb_serial_alu.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/serial_alu.sv
// 4-bit 74181-style ALU: ripple chain of four 1-bit slices with registered result and carry vector.
// Optional Z/V flag outputs are built when SERIAL_ALU_FLAGS_EN is defined.
module serial_alu (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic [3:0] S,
    input  logic       M,
    input  logic       Pin,
    output logic [3:0] R,
    output logic [3:0] P
`ifdef SERIAL_ALU_FLAGS_EN
    ,
    output logic       Z,
    output logic       V
`endif
);

    function automatic logic [3:0] operand_x(input logic [3:0] s, input logic [3:0] a, input logic [3:0] b);
        logic [3:0] x;
        case (s)
            4'b0001, 4'b0101, 4'b1101: x = a | b;
            4'b0010, 4'b1010, 4'b1110: x = a | ~b;
            4'b0011:                   x = 4'b0000;
            4'b0111:                   x = a & ~b;
            4'b1011:                   x = a & b;
            default:                   x = a;
        endcase
        return x;
    endfunction

    function automatic logic [3:0] operand_y(input logic [3:0] s, input logic [3:0] a, input logic [3:0] b);
        logic [3:0] y;
        case (s)
            4'b0000, 4'b0001, 4'b0010:          y = 4'b0000;
            4'b0011, 4'b0111, 4'b1011, 4'b1111: y = 4'b1111;
            4'b0100, 4'b0101:                   y = a & ~b;
            4'b0110:                            y = ~b;
            4'b1000, 4'b1010:                   y = a & b;
            4'b1001:                            y = b;
            4'b1100, 4'b1101, 4'b1110:          y = a;
            default:                            y = 4'b0000;
        endcase
        return y;
    endfunction

    function automatic logic [3:0] logic_op(input logic [3:0] s, input logic [3:0] a, input logic [3:0] b);
        logic [3:0] f;
        case (s)
            4'b0000: f = ~a;
            4'b0001: f = ~(a | b);
            4'b0010: f = ~a & b;
            4'b0011: f = 4'b0000;
            4'b0100: f = ~(a & b);
            4'b0101: f = ~b;
            4'b0110: f = a ^ b;
            4'b0111: f = a & ~b;
            4'b1000: f = ~a | b;
            4'b1001: f = ~(a ^ b);
            4'b1010: f = b;
            4'b1011: f = a & b;
            4'b1100: f = 4'b1111;
            4'b1101: f = a | ~b;
            4'b1110: f = a | b;
            4'b1111: f = a;
            default: f = 4'b0000;
        endcase
        return f;
    endfunction

    logic [3:0] x_s;
    logic [3:0] y_s;
    logic [3:0] sum_s;
    logic [4:0] carry_s;
    logic [3:0] r_next_s;
    logic [3:0] p_next_s;
    logic [3:0] r_r;
    logic [3:0] p_r;

    assign x_s = operand_x(S, A, B);
    assign y_s = operand_y(S, A, B);

    // Bit-serial ripple through the four full-adder slices.
    always_comb begin
        sum_s      = 4'b0000;
        carry_s    = 5'b00000;
        carry_s[0] = Pin;
        for (int i = 0; i < 4; i++) begin
            sum_s[i]       = x_s[i] ^ y_s[i] ^ carry_s[i];
            carry_s[i + 1] = (x_s[i] & y_s[i]) | (x_s[i] & carry_s[i]) | (y_s[i] & carry_s[i]);
        end
    end

    // Mode select: logic mode ignores carries and reports an all-zero carry vector.
    always_comb begin
        r_next_s = 4'b0000;
        p_next_s = 4'b0000;
        if (M) begin
            r_next_s = logic_op(S, A, B);
            p_next_s = 4'b0000;
        end else begin
            r_next_s = sum_s;
            p_next_s = carry_s[4:1];
        end
    end

    // Result and carry-vector registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_r <= 4'b0000;
            p_r <= 4'b0000;
        end else begin
            r_r <= r_next_s;
            p_r <= p_next_s;
        end
    end

    assign R = r_r;
    assign P = p_r;

`ifdef SERIAL_ALU_FLAGS_EN
    logic z_r;
    logic v_r;

    // Zero and signed-overflow flags, aligned with R.
    always_ff @(posedge clk) begin
        if (rst) begin
            z_r <= 1'b0;
            v_r <= 1'b0;
        end else begin
            z_r <= (r_next_s == 4'b0000);
            v_r <= M ? 1'b0 : (carry_s[3] ^ carry_s[4]);
        end
    end

    assign Z = z_r;
    assign V = v_r;
`endif

endmodule

// File: tb/tb_serial_alu.sv
// Self-checking bench for serial_alu: directed cases plus randomized operations against an arithmetic reference model.
module tb_serial_alu;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] A   = 4'd0;
    logic [3:0] B   = 4'd0;
    logic [3:0] S   = 4'd0;
    logic       M   = 1'b0;
    logic       Pin = 1'b0;
    logic [3:0] R;
    logic [3:0] P;
`ifdef SERIAL_ALU_FLAGS_EN
    logic       Z;
    logic       V;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    logic [3:0] last_r;
    logic [3:0] last_p;

    always #5 clk = ~clk;

    serial_alu dut (
        .clk (clk),
        .rst (rst),
        .A   (A),
        .B   (B),
        .S   (S),
        .M   (M),
        .Pin (Pin),
        .R   (R),
        .P   (P)
`ifdef SERIAL_ALU_FLAGS_EN
        ,
        .Z   (Z),
        .V   (V)
`endif
    );

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Reference: arithmetic as integer addition; carry out of slice i from the sum of the low i+1 bits.
    function automatic void model(input int a, input int b, input int s, input int m, input int pin,
                                  output logic [3:0] er, output logic [3:0] ep,
                                  output logic ez, output logic ev);
        int x, y, t, na, nb;
        na = (~a) & 15;
        nb = (~b) & 15;
        er = 4'd0;
        ep = 4'd0;
        if (m == 1) begin
            case (s)
                0:  t = na;            1:  t = (~(a | b)) & 15;
                2:  t = na & b;        3:  t = 0;
                4:  t = (~(a & b)) & 15; 5: t = nb;
                6:  t = a ^ b;         7:  t = a & nb;
                8:  t = na | b;        9:  t = (~(a ^ b)) & 15;
                10: t = b;             11: t = a & b;
                12: t = 15;            13: t = a | nb;
                14: t = a | b;         default: t = a;
            endcase
            er = t[3:0];
            ev = 1'b0;
        end else begin
            case (s)
                0:  begin x = a;       y = 0;      end
                1:  begin x = a | b;   y = 0;      end
                2:  begin x = a | nb;  y = 0;      end
                3:  begin x = 0;       y = 15;     end
                4:  begin x = a;       y = a & nb; end
                5:  begin x = a | b;   y = a & nb; end
                6:  begin x = a;       y = nb;     end
                7:  begin x = a & nb;  y = 15;     end
                8:  begin x = a;       y = a & b;  end
                9:  begin x = a;       y = b;      end
                10: begin x = a | nb;  y = a & b;  end
                11: begin x = a & b;   y = 15;     end
                12: begin x = a;       y = a;      end
                13: begin x = a | b;   y = a;      end
                14: begin x = a | nb;  y = a;      end
                default: begin x = a;  y = 15;     end
            endcase
            t  = (x + y + pin) % 16;
            er = t[3:0];
            for (int i = 0; i < 4; i++) begin
                int mask;
                mask = (1 << (i + 1)) - 1;
                ep[i] = (((x & mask) + (y & mask) + pin) >> (i + 1)) != 0;
            end
            ev = ep[2] ^ ep[3];
        end
        ez = (er == 4'd0);
    endfunction

    // Drive one op, confirm the old result holds until the edge, then check the new one.
    task automatic run_op(input string tag, input int a, input int b, input int s, input int m, input int pin,
                          input logic [3:0] er, input logic [3:0] ep, input logic ez, input logic ev);
        A   = a[3:0];
        B   = b[3:0];
        S   = s[3:0];
        M   = m[0];
        Pin = pin[0];
        #1;
        check({tag, "_holdR"}, R, last_r);
        @(posedge clk);
        #1;
        check({tag, "_R"}, R, er);
        check({tag, "_P"}, P, ep);
`ifdef SERIAL_ALU_FLAGS_EN
        check({tag, "_Z"}, {3'b000, Z}, {3'b000, ez});
        check({tag, "_V"}, {3'b000, V}, {3'b000, ev});
`endif
        last_r = er;
        last_p = ep;
    endtask

    initial begin
        logic [3:0] er, ep;
        logic       ez, ev;
        int a, b, s, m, pin;

        // Reset held for two edges with a live operation on the inputs.
        rst = 1'b1; A = 4'd15; B = 4'd15; M = 1'b0; S = 4'b1001; Pin = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            check("rst_R", R, 4'b0000);
            check("rst_P", P, 4'b0000);
`ifdef SERIAL_ALU_FLAGS_EN
            check("rst_ZV", {2'b00, Z, V}, 4'b0000);
`endif
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rel_R", R, 4'b1111);
        check("rel_P", P, 4'b1111);
        last_r = 4'b1111;
        last_p = 4'b1111;

        run_op("or0",        1, 9,  1, 0, 0, 4'b1001, 4'b0000, 1'b0, 1'b0);
        run_op("a_anb",      7, 15, 4, 0, 0, 4'b0111, 4'b0000, 1'b0, 1'b0);
        run_op("add_wrap",   7, 9,  9, 0, 0, 4'b0000, 4'b1111, 1'b1, 1'b0);
        run_op("add_wrap_c", 7, 9,  9, 0, 1, 4'b0001, 4'b1111, 1'b0, 1'b0);
        run_op("sub",        5, 3,  6, 0, 1, 4'b0010, 4'b1101, 1'b0, 1'b0);
        run_op("sub_borrow", 3, 5,  6, 0, 1, 4'b1110, 4'b0011, 1'b0, 1'b0);
        run_op("lxor",       10, 2, 6, 1, 1, 4'b1000, 4'b0000, 1'b0, 1'b0);
        run_op("lxnor",      3, 11, 9, 1, 0, 4'b0111, 4'b0000, 1'b0, 1'b0);
        run_op("v_ovf",      7, 1,  9, 0, 0, 4'b1000, 4'b0111, 1'b0, 1'b1);

        // Every mode/function code with random operands.
        for (int code = 0; code < 32; code++) begin
            a = $urandom_range(15); b = $urandom_range(15); pin = $urandom_range(1);
            m = code / 16; s = code % 16;
            model(a, b, s, m, pin, er, ep, ez, ev);
            run_op($sformatf("code%0d", code), a, b, s, m, pin, er, ep, ez, ev);
        end

        // Back-to-back random operations, one mid-run reset.
        for (int k = 0; k < 300; k++) begin
            if (k == 150) begin
                rst = 1'b1;
                A = 4'($urandom_range(15)); B = 4'($urandom_range(15)); S = 4'($urandom_range(15));
                M = 1'b0; Pin = 1'b1;
                @(posedge clk);
                #1;
                check("mid_rst_R", R, 4'b0000);
                check("mid_rst_P", P, 4'b0000);
                rst = 1'b0;
                last_r = 4'b0000;
                last_p = 4'b0000;
            end
            a = $urandom_range(15); b = $urandom_range(15); s = $urandom_range(15);
            m = $urandom_range(1);  pin = $urandom_range(1);
            model(a, b, s, m, pin, er, ep, ez, ev);
            run_op($sformatf("rnd%0d_m%0d_s%0d", k, m, s), a, b, s, m, pin, er, ep, ez, ev);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
